// File: rtl/cv32e40p_sleep_ctrl.sv
// Sleep/wake controller feeding the core clock gate enable; runs on the free-running clock.
// Optional gated-cycle statistic enabled by defining CV32E40P_SLEEP_STATS_EN.
module cv32e40p_sleep_ctrl #(
   parameter int WAKE_DELAY = 2
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        fetch_enable_i,
   input  logic        wfi_req_i,
   input  logic        fetch_busy_i,
   input  logic        lsu_busy_i,
   input  logic        irq_pending_i,
   input  logic        debug_req_i,
   output logic        core_clock_en_o,
   output logic        core_sleep_o,
   output logic        wake_o,
   output logic [31:0] sleep_cycles_o
);

   localparam int CNT_W = (WAKE_DELAY > 0) ? $clog2(WAKE_DELAY + 1) : 1;

   localparam logic [2:0] S_OFF   = 3'd0;
   localparam logic [2:0] S_RUN   = 3'd1;
   localparam logic [2:0] S_DRAIN = 3'd2;
   localparam logic [2:0] S_SLEEP = 3'd3;
   localparam logic [2:0] S_WAKE  = 3'd4;

   logic [2:0]       r_state;
   logic             r_en;
   logic             r_sleep;
   logic             r_wake;
   logic [CNT_W-1:0] r_cnt;

   logic [2:0]       w_state_nxt;
   logic             w_en_nxt;
   logic             w_sleep_nxt;
   logic             w_wake_nxt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             w_wake_src;

   assign w_wake_src = irq_pending_i | debug_req_i;

   // Next-state, wake counter and wake pulse decode
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_wake_nxt  = 1'b0;
      case (r_state)
         S_OFF: begin
            if (fetch_enable_i) w_state_nxt = S_RUN;
            else                w_state_nxt = S_OFF;
         end
         S_RUN: begin
            if (wfi_req_i && !w_wake_src) w_state_nxt = S_DRAIN;
            else                          w_state_nxt = S_RUN;
         end
         S_DRAIN: begin
            // A wake source aborts the WFI before the clock is ever gated
            if (w_wake_src)                        w_state_nxt = S_RUN;
            else if (!fetch_busy_i && !lsu_busy_i) w_state_nxt = S_SLEEP;
            else                                   w_state_nxt = S_DRAIN;
         end
         S_SLEEP: begin
            if (w_wake_src) begin
               if (WAKE_DELAY == 0) begin
                  w_state_nxt = S_RUN;
                  w_wake_nxt  = 1'b1;
               end else begin
                  w_state_nxt = S_WAKE;
                  w_cnt_nxt   = CNT_W'(WAKE_DELAY);
               end
            end else begin
               w_state_nxt = S_SLEEP;
            end
         end
         S_WAKE: begin
            if (r_cnt <= CNT_W'(1)) begin
               w_state_nxt = S_RUN;
               w_cnt_nxt   = {CNT_W{1'b0}};
               w_wake_nxt  = 1'b1;
            end else begin
               w_state_nxt = S_WAKE;
               w_cnt_nxt   = r_cnt - CNT_W'(1);
            end
         end
         default: begin
            w_state_nxt = S_OFF;
            w_cnt_nxt   = {CNT_W{1'b0}};
         end
      endcase
   end

   // Output levels follow the state being entered so they register with it
   always_comb begin
      w_en_nxt    = 1'b0;
      w_sleep_nxt = 1'b1;
      case (w_state_nxt)
         S_RUN:   begin w_en_nxt = 1'b1; w_sleep_nxt = 1'b0; end
         S_DRAIN: begin w_en_nxt = 1'b1; w_sleep_nxt = 1'b0; end
         S_WAKE:  begin w_en_nxt = 1'b1; w_sleep_nxt = 1'b1; end
         default: begin w_en_nxt = 1'b0; w_sleep_nxt = 1'b1; end
      endcase
   end

   // State and registered outputs
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_state <= S_OFF;
         r_en    <= 1'b0;
         r_sleep <= 1'b1;
         r_wake  <= 1'b0;
         r_cnt   <= {CNT_W{1'b0}};
      end else begin
         r_state <= w_state_nxt;
         r_en    <= w_en_nxt;
         r_sleep <= w_sleep_nxt;
         r_wake  <= w_wake_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   assign core_clock_en_o = r_en;
   assign core_sleep_o    = r_sleep;
   assign wake_o          = r_wake;

`ifdef CV32E40P_SLEEP_STATS_EN
   logic [31:0] r_sleep_cycles;

   // Saturating count of edges spent in SLEEP
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_sleep_cycles <= 32'd0;
      end else if ((r_state == S_SLEEP) && (r_sleep_cycles != 32'hFFFF_FFFF)) begin
         r_sleep_cycles <= r_sleep_cycles + 32'd1;
      end else begin
         r_sleep_cycles <= r_sleep_cycles;
      end
   end

   assign sleep_cycles_o = r_sleep_cycles;
`else
   assign sleep_cycles_o = 32'd0;
`endif

endmodule

// File: tb/tb_cv32e40p_sleep_ctrl.sv
// Scoreboard bench for cv32e40p_sleep_ctrl: stimulus pushes expected outputs, a monitor pops and compares.
module tb_cv32e40p_sleep_ctrl;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        fetch_enable_i = 1'b0;
   logic        wfi_req_i = 1'b0;
   logic        fetch_busy_i = 1'b0;
   logic        lsu_busy_i = 1'b0;
   logic        irq_pending_i = 1'b0;
   logic        debug_req_i = 1'b0;
   logic        core_clock_en_o;
   logic        core_sleep_o;
   logic        wake_o;
   logic [31:0] sleep_cycles_o;

   always #5 clk_i = ~clk_i;

   cv32e40p_sleep_ctrl #(.WAKE_DELAY(2)) dut (
      .clk_i           (clk_i),
      .rst_ni          (rst_ni),
      .fetch_enable_i  (fetch_enable_i),
      .wfi_req_i       (wfi_req_i),
      .fetch_busy_i    (fetch_busy_i),
      .lsu_busy_i      (lsu_busy_i),
      .irq_pending_i   (irq_pending_i),
      .debug_req_i     (debug_req_i),
      .core_clock_en_o (core_clock_en_o),
      .core_sleep_o    (core_sleep_o),
      .wake_o          (wake_o),
      .sleep_cycles_o  (sleep_cycles_o)
   );

   typedef struct {
      logic        en;
      logic        sl;
      logic        wk;
      logic [31:0] st;
      string       nm;
   } exp_t;

   exp_t        q[$];
   int          total = 0;
   int          bad = 0;
   logic [31:0] model_cnt = 32'd0;
   logic        prev_slp = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // One clock of stimulus; expected outputs after the following rising edge.
   // slp marks that the DUT is expected to sit in SLEEP after this edge.
   task automatic cyc(input logic fe, input logic wfi, input logic fb, input logic lb,
                      input logic irq, input logic dbg, input logic rst,
                      input logic e_en, input logic e_sl, input logic e_wk,
                      input logic slp, input string nm);
      exp_t e;
      @(negedge clk_i);
      fetch_enable_i = fe;
      wfi_req_i      = wfi;
      fetch_busy_i   = fb;
      lsu_busy_i     = lb;
      irq_pending_i  = irq;
      debug_req_i    = dbg;
      rst_ni         = rst;
      if (!rst)          model_cnt = 32'd0;
      else if (prev_slp) model_cnt = model_cnt + 32'd1;
      prev_slp = slp & rst;
      e.en = e_en;
      e.sl = e_sl;
      e.wk = e_wk;
`ifdef CV32E40P_SLEEP_STATS_EN
      e.st = model_cnt;
`else
      e.st = 32'd0;
`endif
      e.nm = nm;
      q.push_back(e);
   endtask

   // Monitor: compares the DUT outputs after every edge that has a pending expectation
   initial begin
      forever begin
         exp_t e;
         @(posedge clk_i);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            chk({e.nm, ".en"},    {31'd0, core_clock_en_o}, {31'd0, e.en});
            chk({e.nm, ".sleep"}, {31'd0, core_sleep_o},    {31'd0, e.sl});
            chk({e.nm, ".wake"},  {31'd0, wake_o},          {31'd0, e.wk});
            chk({e.nm, ".stats"}, sleep_cycles_o,           e.st);
         end
      end
   end

   initial begin
      //        fe    wfi   fb    lb    irq   dbg   rst    en    sl    wk    slp
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,  1'b0, 1'b1, 1'b0, 1'b0, "reset");
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,  1'b0, 1'b1, 1'b0, 1'b0, "reset_hold");
      for (int i = 0; i < 10; i++)
         cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,  1'b0, 1'b1, 1'b0, 1'b0, "off_idle");
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,  1'b1, 1'b0, 1'b0, 1'b0, "start");
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,  1'b1, 1'b0, 1'b0, 1'b0, "run_fe_low");

      // WFI with LSU busy for five cycles
      cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1,  1'b1, 1'b0, 1'b0, 1'b0, "drain_enter");
      for (int i = 0; i < 4; i++)
         cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1,  1'b1, 1'b0, 1'b0, 1'b0, "drain_busy");
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,  1'b0, 1'b1, 1'b0, 1'b1, "gate_off");
      for (int i = 0; i < 3; i++)
         cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1,  1'b0, 1'b1, 1'b0, 1'b1, "sleep_hold");

      // Wake by interrupt, source drops mid-wake without aborting
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1,  1'b1, 1'b1, 1'b0, 1'b0, "wake_m1");
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,  1'b1, 1'b1, 1'b0, 1'b0, "wake_m2");
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,  1'b1, 1'b0, 1'b1, 1'b0, "wake_m3");
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,  1'b1, 1'b0, 1'b0, 1'b0, "wake_done");

      // Interrupt during DRAIN aborts back to RUN
      cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1,  1'b1, 1'b0, 1'b0, 1'b0, "abort_drain");
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1,  1'b1, 1'b0, 1'b0, 1'b0, "abort_irq");
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,  1'b1, 1'b0, 1'b0, 1'b0, "abort_run");

      // WFI coinciding with a wake source is a no-op
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1,  1'b1, 1'b0, 1'b0, 1'b0, "wfi_dbg");
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,  1'b1, 1'b0, 1'b0, 1'b0, "wfi_dbg_run");
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1,  1'b1, 1'b0, 1'b0, 1'b0, "wfi_irq");
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,  1'b1, 1'b0, 1'b0, 1'b0, "wfi_irq_run");

      // Reset while sleeping; interrupts ignored in OFF
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,  1'b1, 1'b0, 1'b0, 1'b0, "drain_fast");
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,  1'b0, 1'b1, 1'b0, 1'b1, "gate_fast");
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,  1'b0, 1'b1, 1'b0, 1'b1, "sleep_pre_rst");
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,  1'b0, 1'b1, 1'b0, 1'b0, "rst_sleep");
      for (int i = 0; i < 3; i++)
         cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1,  1'b0, 1'b1, 1'b0, 1'b0, "off_after_rst");
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,  1'b1, 1'b0, 1'b0, 1'b0, "restart");

      // Long sleep for the statistic, woken by debug request
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,  1'b1, 1'b0, 1'b0, 1'b0, "stat_drain");
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,  1'b0, 1'b1, 1'b0, 1'b1, "stat_gate");
      for (int i = 0; i < 100; i++)
         cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,  1'b0, 1'b1, 1'b0, 1'b1, "stat_sleep");
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1,  1'b1, 1'b1, 1'b0, 1'b0, "dbg_wake1");
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1,  1'b1, 1'b1, 1'b0, 1'b0, "dbg_wake2");
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,  1'b1, 1'b0, 1'b1, 1'b0, "dbg_wake3");
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,  1'b1, 1'b0, 1'b0, 1'b0, "dbg_run");

      repeat (3) @(negedge clk_i);
      total++;
      if (q.size() != 0) begin
         bad++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
